fifo_rd_ptr: RTL and testbench
==============================

Name: fifo_rd_ptr

Overview:
- Read-side pointer and flag generator for the dual-clock Ethernet packet FIFO. It lives entirely in the read clock domain.
- Consumes the write pointer (Gray code) after it has been synchronised into the read domain. Produces:
  - the binary read address for the FIFO memory;
  - the Gray read pointer exported to the write domain;
  - empty, almost_empty and occupancy count.
- Supports packet replay: a frame can be re-read (for example, MAC retry) because FIFO space is released to the writer only on commit.

Parameters:
- ADDR_WIDTH, 8, memory address width; depth = 2^ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits.
- ALMOST_EMPTY_DIFF, 4, almost_empty asserts when the word count is <= this value.
- COMMIT_EN, 1, 1 = packet commit/rewind mode; 0 = plain FIFO (commit pointer follows live pointer every cycle; rewind_pckt and commit_pckt ignored).

Ports:
- clk  in  1  read-domain clock
- reset_n  in  1  synchronous, active-low reset
- read  in  1  read request; accepted only when !empty
- empty  out  1  registered, no unread words at live pointer
- almost_empty  out  1  registered, count <= ALMOST_EMPTY_DIFF
- rd_count  out  ADDR_WIDTH+1  registered, words between live read pointer and write pointer
- wr_ptr  in  ADDR_WIDTH+1  write pointer, Gray, already synchronised to clk
- r_addr  out  ADDR_WIDTH  binary memory read address (combinational from live pointer)
- r_ptr  out  ADDR_WIDTH+1  registered Gray of committed pointer, to the write domain
- commit_pckt  in  1  release all words read so far (end of a successfully sent frame)
- rewind_pckt  in  1  restore live pointer to the committed pointer (replay the frame)

Behaviour:
- Reset: rd_ptr_bin=0, cmt_ptr_bin=0, r_ptr=0, empty=1, almost_empty=1, rd_count=0. r_addr=0 follows.
- Gray to binary, combinational:
  - wr_bin[MSB] = wr_ptr[MSB];
  - wr_bin[i] = wr_bin[i+1] ^ wr_ptr[i], descending.
- Binary to Gray: g = b ^ (b >> 1).
- All pointer arithmetic is modulo 2^(ADDR_WIDTH+1). The extra MSB is the wrap bit.
- Next live pointer, in priority order:
  1. rewind_pckt (COMMIT_EN=1): nxt = cmt_ptr_bin. read is ignored that cycle.
  2. Otherwise: nxt = rd_ptr_bin + (read & !empty). read while empty has no effect.
- rd_ptr_bin <= nxt each cycle. r_addr = rd_ptr_bin[ADDR_WIDTH-1:0]. The data address advances the cycle after an accepted read.
- Commit pointer:
  - COMMIT_EN=0: cmt_ptr_bin <= nxt every cycle.
  - COMMIT_EN=1:
    - commit_pckt & !rewind_pckt: cmt_ptr_bin <= nxt. This includes a read accepted in the same cycle.
    - commit_pckt & rewind_pckt: rewind wins; the commit is dropped.
    - Otherwise: cmt_ptr_bin holds.
- r_ptr <= gray(next cmt_ptr_bin value). The writer sees freed space one clk after commit, plus synchroniser latency. r_ptr never moves backwards.
- Registered flags, each computed from nxt and the current wr_bin:
  - empty <= (gray(nxt) == wr_ptr);
  - rd_count <= wr_bin - nxt;
  - almost_empty <= ((wr_bin - nxt) <= ALMOST_EMPTY_DIFF).
- Latency of flags:
  - A read that drains the last word sets empty on the next edge. No extra read can be accepted.
  - A new write (wr_ptr change) clears empty one clk after wr_ptr changes.
- Invariants: cmt_ptr_bin <= rd_ptr_bin <= wr_bin, in modular distance terms. rd_count never exceeds 2^ADDR_WIDTH.
- Wrap-around: pointers roll from 2^(ADDR_WIDTH+1)-1 to 0 with no special case. The MSB toggles every full pass.
- Rewind with no reads since the last commit: no-op.
- Rewind re-derives empty, almost_empty and rd_count from the restored pointer on the next edge.
- Reset asserted mid-packet: all state returns to reset values on that edge; uncommitted reads are lost. The write side must be reset together.

Test Plan:
- ADDR_WIDTH=4, ALMOST_EMPTY_DIFF=4, COMMIT_EN=0. Drive wr_ptr Gray of 5, read 5 words -> r_addr 0..4; empty=1 after 5th read; rd_count 5..0; almost_empty=1 once count<=4; r_ptr = Gray(5) = 0x07.
- Read held high while empty=1 and wr_ptr static -> r_addr, r_ptr, rd_count unchanged for 10 cycles.
- COMMIT_EN=1. wr=8, read 6 words, assert rewind_pckt -> r_addr returns to 0 next cycle; rd_count=8; r_ptr stays 0 throughout.
- Read 6 words, then commit_pckt in the same cycle as the 7th read -> r_ptr = Gray(7) = 0x04; further reads continue from address 7.
- rewind_pckt, commit_pckt and read all high together after 3 uncommitted reads -> live pointer returns to the committed value; r_ptr unchanged; read not counted.
- Wrap: stream 40 words through a 16-deep FIFO with periodic commits -> r_addr wraps 15->0; r_ptr MSB toggles at 16 and 32; no spurious empty; reset mid-stream -> empty=1, r_ptr=0 next cycle.

Source files
------------

// File: rtl/fifo_rd_ptr.sv
// Read-side pointer and flag generator for the dual-clock packet FIFO.
// Lives in the read clock domain; supports commit/rewind for frame replay.
module fifo_rd_ptr #(
    parameter int ADDR_WIDTH        = 8,
    parameter int ALMOST_EMPTY_DIFF = 4,
    parameter int COMMIT_EN         = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  read,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   rd_count,
    input  logic [ADDR_WIDTH:0]   wr_ptr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic [ADDR_WIDTH:0]   r_ptr,
    input  logic                  commit_pckt,
    input  logic                  rewind_pckt
);

    localparam int PW = ADDR_WIDTH + 1;
    localparam logic [PW-1:0] AE_LIMIT = PW'(ALMOST_EMPTY_DIFF);

    logic [PW-1:0] rd_ptr_bin;
    logic [PW-1:0] cmt_ptr_bin;
    logic [PW-1:0] wr_bin;
    logic [PW-1:0] nxt;
    logic [PW-1:0] cmt_nxt;
    logic [PW-1:0] diff_nxt;
    logic          do_rewind;
    logic          do_commit;
    logic          accept;

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    always_comb begin : g2b
        logic [PW-1:0] b;
        b         = '0;
        b[PW-1]   = wr_ptr[PW-1];
        for (int unsigned i = PW - 1; i > 0; i--) begin
            b[i-1] = b[i] ^ wr_ptr[i-1];
        end
        wr_bin = b;
    end

    // Rewind outranks both commit and read; in plain mode the commit
    // pointer simply tracks the live pointer.
    always_comb begin
        do_rewind = (COMMIT_EN != 0) && rewind_pckt;
        do_commit = (COMMIT_EN == 0) || (commit_pckt && !rewind_pckt);
        accept    = read && !empty && !do_rewind;
        nxt       = do_rewind ? cmt_ptr_bin : rd_ptr_bin + PW'(accept);
        cmt_nxt   = do_commit ? nxt : cmt_ptr_bin;
        diff_nxt  = wr_bin - nxt;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_ptr_bin   <= '0;
            cmt_ptr_bin  <= '0;
            r_ptr        <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            rd_count     <= '0;
        end else begin
            rd_ptr_bin   <= nxt;
            cmt_ptr_bin  <= cmt_nxt;
            r_ptr        <= bin2gray(cmt_nxt);
            empty        <= (bin2gray(nxt) == wr_ptr);
            rd_count     <= diff_nxt;
            almost_empty <= (diff_nxt <= AE_LIMIT);
        end
    end

    assign r_addr = rd_ptr_bin[ADDR_WIDTH-1:0];

endmodule

// File: tb/tb_fifo_rd_ptr.sv
// Bench for fifo_rd_ptr: plain-mode and commit-mode instances checked
// against a word-index model of the read side.
`timescale 1ns/1ps
module tb_fifo_rd_ptr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset_n;
    logic       rd [2];
    logic       cm [2];
    logic       rw [2];
    logic [4:0] wp [2];
    logic       empty [2];
    logic       ae [2];
    logic [4:0] cnt [2];
    logic [4:0] rptr [2];
    logic [3:0] raddr [2];

    // model: unbounded word indices; hardware pointers are these mod 32
    int   m_live [2];
    int   m_cmt [2];
    int   m_wr [2];
    int   m_cnt [2];
    logic m_empty [2];
    logic m_ae [2];

    int total = 0;
    int bad   = 0;

    fifo_rd_ptr #(.ADDR_WIDTH(4), .ALMOST_EMPTY_DIFF(4), .COMMIT_EN(0)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .read(rd[0]), .empty(empty[0]),
        .almost_empty(ae[0]), .rd_count(cnt[0]), .wr_ptr(wp[0]), .r_addr(raddr[0]),
        .r_ptr(rptr[0]), .commit_pckt(cm[0]), .rewind_pckt(rw[0])
    );

    fifo_rd_ptr #(.ADDR_WIDTH(4), .ALMOST_EMPTY_DIFF(4), .COMMIT_EN(1)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .read(rd[1]), .empty(empty[1]),
        .almost_empty(ae[1]), .rd_count(cnt[1]), .wr_ptr(wp[1]), .r_addr(raddr[1]),
        .r_ptr(rptr[1]), .commit_pckt(cm[1]), .rewind_pckt(rw[1])
    );

    function automatic logic [4:0] gray5(input int b);
        logic [31:0] w;
        logic [4:0]  v;
        w = b;
        v = w[4:0];
        return v ^ (v >> 1);
    endfunction

    function automatic logic [15:0] obs(input int k);
        return {raddr[k], rptr[k], cnt[k], empty[k], ae[k]};
    endfunction

    function automatic logic [15:0] expv(input int k);
        logic [31:0] l, c;
        l = m_live[k];
        c = m_cnt[k];
        return {l[3:0], gray5(m_cmt[k]), c[4:0], m_empty[k], m_ae[k]};
    endfunction

    task automatic set_wr(input int k, input int v);
        m_wr[k] = v;
        wp[k]   = gray5(v);
    endtask

    task automatic tick();
        int nl [2];
        int nc [2];
        bit rwd, acc, in_rst;
        in_rst = !reset_n;
        for (int k = 0; k < 2; k++) begin
            if (in_rst) begin
                nl[k] = 0;
                nc[k] = 0;
            end else begin
                rwd   = (k == 1) && rw[k];
                acc   = rd[k] && !m_empty[k] && !rwd;
                nl[k] = rwd ? m_cmt[k] : m_live[k] + int'(acc);
                nc[k] = (k == 0 || (cm[k] && !rw[k])) ? nl[k] : m_cmt[k];
            end
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            m_live[k]  = nl[k];
            m_cmt[k]   = nc[k];
            m_cnt[k]   = m_wr[k] - nl[k];
            m_empty[k] = (m_wr[k] == nl[k]);
            m_ae[k]    = (m_cnt[k] <= 4);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rd[k] = 1'b0; cm[k] = 1'b0; rw[k] = 1'b0;
            set_wr(k, 0);
        end
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obs(k) !== 16'h0003) begin
                bad++;
                $display("FAIL reset[%0d]: got %h expected %h", k, obs(k), 16'h0003);
            end
        end
    endtask

    task automatic test_plain_read();
        set_wr(0, 5);
        tick();
        total++;
        if (obs(0) !== expv(0)) begin
            bad++;
            $display("FAIL plain_load: got %h expected %h", obs(0), expv(0));
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (raddr[0] !== 4'(i) || cnt[0] !== 5'(5 - i)) begin
                bad++;
                $display("FAIL plain_addr%0d: got addr=%0d cnt=%0d expected addr=%0d cnt=%0d",
                         i, raddr[0], cnt[0], i, 5 - i);
            end
            rd[0] = 1'b1;
            tick();
            total++;
            if (obs(0) !== expv(0)) begin
                bad++;
                $display("FAIL plain_step%0d: got %h expected %h", i, obs(0), expv(0));
            end
        end
        rd[0] = 1'b0;
        total++;
        if ({empty[0], cnt[0], rptr[0], ae[0]} !== {1'b1, 5'd0, 5'h07, 1'b1}) begin
            bad++;
            $display("FAIL plain_drained: got e=%b cnt=%0d rptr=%h ae=%b expected e=1 cnt=0 rptr=07 ae=1",
                     empty[0], cnt[0], rptr[0], ae[0]);
        end
    endtask

    task automatic test_read_empty();
        rd[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if ({raddr[0], rptr[0], cnt[0], empty[0]} !== {4'd5, 5'h07, 5'd0, 1'b1}) begin
                bad++;
                $display("FAIL read_empty%0d: got addr=%0d rptr=%h cnt=%0d e=%b expected addr=5 rptr=07 cnt=0 e=1",
                         i, raddr[0], rptr[0], cnt[0], empty[0]);
            end
        end
        rd[0] = 1'b0;
    endtask

    task automatic test_rewind();
        do_reset();
        set_wr(1, 8);
        tick();
        rd[1] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            total++;
            if (obs(1) !== expv(1) || rptr[1] !== 5'h00) begin
                bad++;
                $display("FAIL rewind_read%0d: got %h expected %h", i, obs(1), expv(1));
            end
        end
        rd[1] = 1'b0;
        rw[1] = 1'b1;
        tick();
        rw[1] = 1'b0;
        total++;
        if ({raddr[1], cnt[1], rptr[1], empty[1]} !== {4'd0, 5'd8, 5'h00, 1'b0}) begin
            bad++;
            $display("FAIL rewind: got addr=%0d cnt=%0d rptr=%h e=%b expected addr=0 cnt=8 rptr=00 e=0",
                     raddr[1], cnt[1], rptr[1], empty[1]);
        end
    endtask

    task automatic test_commit_with_read();
        do_reset();
        set_wr(1, 12);
        tick();
        rd[1] = 1'b1;
        repeat (6) tick();
        cm[1] = 1'b1;
        tick();
        cm[1] = 1'b0;
        rd[1] = 1'b0;
        total++;
        if (rptr[1] !== 5'h04 || raddr[1] !== 4'd7) begin
            bad++;
            $display("FAIL commit_read: got rptr=%h addr=%0d expected rptr=04 addr=7", rptr[1], raddr[1]);
        end
    endtask

    task automatic test_all_three();
        rd[1] = 1'b1;
        repeat (3) tick();
        total++;
        if (raddr[1] !== 4'd10 || rptr[1] !== 5'h04) begin
            bad++;
            $display("FAIL three_pre: got addr=%0d rptr=%h expected addr=10 rptr=04", raddr[1], rptr[1]);
        end
        cm[1] = 1'b1;
        rw[1] = 1'b1;
        tick();
        rd[1] = 1'b0; cm[1] = 1'b0; rw[1] = 1'b0;
        total++;
        if ({raddr[1], rptr[1], cnt[1]} !== {4'd7, 5'h04, 5'd5}) begin
            bad++;
            $display("FAIL all_three: got addr=%0d rptr=%h cnt=%0d expected addr=7 rptr=04 cnt=5",
                     raddr[1], rptr[1], cnt[1]);
        end
    endtask

    task automatic test_wrap();
        int   toggles = 0;
        bit   wrapped = 0;
        bit   done    = 0;
        logic prev_msb;
        logic [3:0] prev_addr;
        do_reset();
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            if (m_wr[1] < 40 && m_wr[1] - m_cmt[1] < 16) set_wr(1, m_wr[1] + 1);
            rd[1] = ($urandom_range(0, 3) != 0);
            cm[1] = (cyc % 4 == 3);
            prev_msb  = rptr[1][4];
            prev_addr = raddr[1];
            tick();
            if (rptr[1][4] !== prev_msb) toggles++;
            if (prev_addr == 4'd15 && raddr[1] == 4'd0) wrapped = 1;
            total++;
            if (obs(1) !== expv(1)) begin
                bad++;
                $display("FAIL wrap_c%0d: got %h expected %h", cyc, obs(1), expv(1));
            end
            if (m_cmt[1] == 40) done = 1;
        end
        rd[1] = 1'b0; cm[1] = 1'b0;
        total++;
        if (!done || !wrapped || toggles != 2) begin
            bad++;
            $display("FAIL wrap_summary: got done=%0d wrapped=%0d toggles=%0d expected 1 1 2",
                     done, wrapped, toggles);
        end
        set_wr(1, m_wr[1] + 6);
        tick();
        rd[1] = 1'b1;
        repeat (3) tick();
        do_reset();
        total++;
        if ({empty[1], rptr[1], raddr[1], cnt[1]} !== {1'b1, 5'h00, 4'd0, 5'd0}) begin
            bad++;
            $display("FAIL wrap_reset: got e=%b rptr=%h addr=%0d cnt=%0d expected e=1 rptr=00 addr=0 cnt=0",
                     empty[1], rptr[1], raddr[1], cnt[1]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int k = 0; k < 2; k++) begin
                if ($urandom_range(0, 1) == 1 && m_wr[k] - m_cmt[k] < 16) set_wr(k, m_wr[k] + 1);
                rd[k] = 1'($urandom_range(0, 1));
                cm[k] = ($urandom_range(0, 3) == 0);
                rw[k] = ($urandom_range(0, 7) == 0);
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obs(k) !== expv(k)) begin
                    bad++;
                    $display("FAIL random[%0d]_c%0d: got %h expected %h", k, cyc, obs(k), expv(k));
                end
            end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        for (int k = 0; k < 2; k++) begin
            rd[k] = 1'b0; cm[k] = 1'b0; rw[k] = 1'b0; wp[k] = '0;
            m_live[k] = 0; m_cmt[k] = 0; m_wr[k] = 0; m_cnt[k] = 0;
            m_empty[k] = 1'b1; m_ae[k] = 1'b1;
        end
        test_reset();
        test_plain_read();
        test_read_empty();
        test_rewind();
        test_commit_with_read();
        test_all_three();
        test_wrap();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
